// File: rtl/sram_arbiter.sv
// Two-port SRAM arbiter with registered async-SRAM pins and fixed wait states.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise port 0 wins.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [18:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_ack,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [18:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_ack,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [18:0] ADR,
    output logic        RAMCS,
    output logic        RAMOE,
    output logic        RAMWE,
    output logic [15:0] dat_out,
    output logic        dat_oe,
    input  logic [15:0] dat_in
);

    typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

    localparam logic [2:0] WC = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        sel_q, sel_d;
    logic        we_q, we_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic [18:0] adr_q, adr_d;
    logic        cs_q, cs_d;
    logic        oe_q, oe_d;
    logic        wen_q, wen_d;
    logic [15:0] dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        gnt_any;
    logic        gnt_sel;

    assign gnt_any = p0_req | p1_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // last_q=1 means port 1 was served last, so port 0 takes the next tie
    assign gnt_sel = p1_req & (~p0_req | ~last_q);
`else
    assign gnt_sel = p1_req & ~p0_req;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    state_d = ACCESS;
                    cnt_d   = WC;
                    sel_d   = gnt_sel;
                    we_d    = gnt_sel ? p1_we : p0_we;
                    addr_d  = gnt_sel ? p1_addr : p0_addr;
                    wdata_d = gnt_sel ? p1_wdata : p0_wdata;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                    last_d  = gnt_sel;
`endif
                end
            end
            ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = HOLD;
                    if (!we_q) rdata_d = dat_in;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pins are computed from the next state so they are registered outputs.
    always_comb begin
        adr_d  = 19'd0;
        cs_d   = 1'b1;
        oe_d   = 1'b1;
        wen_d  = 1'b1;
        dout_d = 16'd0;
        doe_d  = 1'b0;
        case (state_d)
            ACCESS: begin
                cs_d   = 1'b0;
                adr_d  = addr_d;
                oe_d   = we_d;
                wen_d  = ~we_d;
                dout_d = wdata_d;
                doe_d  = we_d;
            end
            HOLD: begin
                cs_d   = 1'b0;
                adr_d  = adr_q;
                dout_d = dout_q;
                doe_d  = we_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 19'd0;
            wdata_q <= 16'd0;
            rdata_q <= 16'd0;
            adr_q   <= 19'd0;
            cs_q    <= 1'b1;
            oe_q    <= 1'b1;
            wen_q   <= 1'b1;
            dout_q  <= 16'd0;
            doe_q   <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            adr_q   <= adr_d;
            cs_q    <= cs_d;
            oe_q    <= oe_d;
            wen_q   <= wen_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign p0_ack  = (state_q == HOLD) & ~sel_q;
    assign p1_ack  = (state_q == HOLD) & sel_q;
    assign busy    = (state_q != IDLE);
    assign rdata   = rdata_q;
    assign ADR     = adr_q;
    assign RAMCS   = cs_q;
    assign RAMOE   = oe_q;
    assign RAMWE   = wen_q;
    assign dat_out = dout_q;
    assign dat_oe  = doe_q;

endmodule
